// File: rtl/sqrt_sched.sv
// Round-robin share of one pipelined 48-bit sqrt between NREQ requesters; result in LAT+1 cycles from issue, rsp stall freezes everything.
// Optional SQRT_SCHED_PRIO0_EN gives requester 0 absolute priority; req_rdy drops combinationally on rsp backpressure.
module sqrt_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*48-1:0]   req_data,
  output logic [NREQ-1:0]      req_rdy,
  output logic                 rsp_vld,
  output logic [23:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  input  logic                 rsp_rdy,
  output logic                 sq_en,
  output logic                 sq_vldin,
  output logic [47:0]          sq_ain,
  input  logic [23:0]          sq_out,
  output logic                 busy,
  output logic [IDW+2:0]       inflight
);

  logic                 run;
  logic                 iss_vld;
  logic [IDW-1:0]       iss_id;
  logic [47:0]          iss_data;
  logic [IDW-1:0]       last;
  logic [LAT-1:0]       tag_vld;
  logic [IDW-1:0]       tag_id [LAT];
  logic                 stall;
  logic                 adv;
  logic                 any_gnt;
  logic [IDW-1:0]       gnt_idx;
  logic [NREQ-1:0]      grant;
  logic [IDW+2:0]       inflight_nxt;

  assign rsp_vld  = tag_vld[LAT-1];
  assign rsp_id   = tag_id[LAT-1];
  assign rsp_data = sq_out;
  assign stall    = rsp_vld & ~rsp_rdy;
  assign adv      = ~stall;
  assign busy     = iss_vld | (|tag_vld);
  assign sq_en    = adv & busy;
  assign sq_vldin = iss_vld;
  assign sq_ain   = iss_data;
  assign req_rdy  = grant & {NREQ{adv}};

  always_comb begin : arb
    logic [NREQ-1:0] cand;
    int              idx;
    cand    = run ? req_vld : '0;
`ifdef SQRT_SCHED_PRIO0_EN
    if (cand[0]) cand = NREQ'(1);
`endif
    any_gnt = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!any_gnt && cand[idx]) begin
        any_gnt = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    if (any_gnt) grant[gnt_idx] = 1'b1;
  end

  // Entries 0..LAT-2 stay occupied whether or not the pipe shifts; only the
  // slot feeding entry 0 and the slot leaving entry LAT-1 depend on sq_en.
  always_comb begin : occ
    int n;
    n = adv ? int'(any_gnt) : int'(iss_vld);
    n += sq_en ? int'(iss_vld) : int'(tag_vld[LAT-1]);
    for (int k = 0; k < LAT-1; k++) n += int'(tag_vld[k]);
    inflight_nxt = (IDW+3)'(n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      iss_vld  <= 1'b0;
      iss_id   <= '0;
      iss_data <= '0;
      last     <= IDW'(NREQ-1);
      tag_vld  <= '0;
      inflight <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= inflight_nxt;
      if (adv) begin
        iss_vld <= any_gnt;
        if (any_gnt) begin
          iss_id   <= gnt_idx;
          iss_data <= req_data[48*gnt_idx +: 48];
          last     <= gnt_idx;
        end
      end
      if (sq_en) begin
        tag_vld   <= {tag_vld[LAT-2:0], iss_vld};
        tag_id[0] <= iss_id;
        for (int k = 1; k < LAT; k++) tag_id[k] <= tag_id[k-1];
      end
    end
  end

endmodule
